// File: rtl/rs232_pkg.sv
// rs232_pkg: shared types and constants for the RS-232 receive path.
//   rx_state_t : receiver FSM states
//   DATA_BITS  : payload bits per frame (8N1)
//   TIMER_W    : width of the per-bit down-counter
package rs232_pkg;

  localparam int DATA_BITS = 8;
  localparam int TIMER_W   = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/rs232_sync.sv
// rs232_sync: two-flop synchroniser for a single asynchronous input.
//   clk      : destination clock
//   reset    : synchronous active-high reset, flops load RESET_VAL
//   async_in : asynchronous input
//   sync_out : synchronised output (second flop), 2-cycle latency
module rs232_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta_r;
  logic sync_r;

  // Two-stage metastability filter, preset to the idle level on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= async_in;
      sync_r <= meta_r;
    end
  end

  assign sync_out = sync_r;

endmodule

// File: rtl/rs232_rx.sv
// rs232_rx: 8N1 UART receiver with a single-entry holding register.
//   clk        : system clock
//   reset      : synchronous active-high reset
//   UART_RX    : asynchronous serial line, idle high
//   data       : received byte, stable while data_valid=1
//   data_valid : holding register full
//   data_ack   : consumer strobe, clears data_valid
//   frame_err  : one-cycle pulse when the stop bit is sampled low
//   uart_ovf   : sticky, a byte completed while the holding register was full
//   receiving  : high whenever the FSM is not in IDLE
// CLKS_PER_BIT must be >= 8 so the half-bit start validation has room.
module rs232_rx
  import rs232_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 UART_RX,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ack,
  output logic                 frame_err,
  output logic                 uart_ovf,
  output logic                 receiving
);

  localparam logic [TIMER_W-1:0] FULL_RELOAD = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [TIMER_W-1:0] HALF_RELOAD = TIMER_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]         LAST_IDX    = 3'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state_r,     state_nxt;
  logic [TIMER_W-1:0]   timer_r,     timer_nxt;
  logic [2:0]           idx_r,       idx_nxt;
  logic [DATA_BITS-1:0] shift_r,     shift_nxt;
  logic [DATA_BITS-1:0] data_r,      data_nxt;
  logic                 valid_r,     valid_nxt;
  logic                 frame_err_r, frame_err_nxt;
  logic                 ovf_r,       ovf_nxt;
  logic                 recv_r,      recv_nxt;

  rs232_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (UART_RX),
    .sync_out (rx_s)
  );

  // Next-state and datapath logic for the receive FSM
  always_comb begin
    state_nxt     = state_r;
    timer_nxt     = timer_r;
    idx_nxt       = idx_r;
    shift_nxt     = shift_r;
    data_nxt      = data_r;
    // Ack is applied first so a same-cycle stop sample sees an empty register
    valid_nxt     = valid_r & ~data_ack;
    frame_err_nxt = 1'b0;
    ovf_nxt       = ovf_r;

    case (state_r)
      IDLE: begin
        if (rx_s == 1'b0) begin
          state_nxt = START;
          timer_nxt = HALF_RELOAD;
        end else begin
          state_nxt = IDLE;
        end
      end

      START: begin
        if (timer_r == {TIMER_W{1'b0}}) begin
          // Still low at mid-bit: genuine start; otherwise a glitch
          if (rx_s == 1'b0) begin
            state_nxt = DATA;
            timer_nxt = FULL_RELOAD;
            idx_nxt   = 3'd0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          timer_nxt = timer_r - 16'd1;
        end
      end

      DATA: begin
        if (timer_r == {TIMER_W{1'b0}}) begin
          shift_nxt[idx_r] = rx_s;
          timer_nxt        = FULL_RELOAD;
          if (idx_r == LAST_IDX) begin
            state_nxt = STOP;
          end else begin
            idx_nxt = idx_r + 3'd1;
          end
        end else begin
          timer_nxt = timer_r - 16'd1;
        end
      end

      STOP: begin
        if (timer_r == {TIMER_W{1'b0}}) begin
          if (rx_s == 1'b1) begin
            state_nxt = IDLE;
            if (valid_nxt == 1'b0) begin
              data_nxt  = shift_r;
              valid_nxt = 1'b1;
            end else begin
              ovf_nxt = 1'b1;
            end
          end else begin
            frame_err_nxt = 1'b1;
            state_nxt     = BREAK;
          end
        end else begin
          timer_nxt = timer_r - 16'd1;
        end
      end

      BREAK: begin
        // Hold off re-arming until the line returns high
        if (rx_s == 1'b1) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = BREAK;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    recv_nxt = (state_nxt != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      timer_r     <= {TIMER_W{1'b0}};
      idx_r       <= 3'd0;
      shift_r     <= {DATA_BITS{1'b0}};
      data_r      <= {DATA_BITS{1'b0}};
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      ovf_r       <= 1'b0;
      recv_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      timer_r     <= timer_nxt;
      idx_r       <= idx_nxt;
      shift_r     <= shift_nxt;
      data_r      <= data_nxt;
      valid_r     <= valid_nxt;
      frame_err_r <= frame_err_nxt;
      ovf_r       <= ovf_nxt;
      recv_r      <= recv_nxt;
    end
  end

  assign data       = data_r;
  assign data_valid = valid_r;
  assign frame_err  = frame_err_r;
  assign uart_ovf   = ovf_r;
  assign receiving  = recv_r;

endmodule

// File: tb/tb_rs232_rx.sv
// tb_rs232_rx: directed self-checking bench for rs232_rx at 100 clocks/bit.
module tb_rs232_rx;

  localparam int CPB = 100;
  localparam int LAT = 2 + CPB / 2 + 9 * CPB;   // 952 cycles pin-fall to data_valid

  logic       clk = 1'b0;
  logic       reset;
  logic       UART_RX;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ack;
  logic       frame_err;
  logic       uart_ovf;
  logic       receiving;

  int vec_cnt = 0;
  int err_cnt = 0;

  rs232_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .UART_RX    (UART_RX),
    .data       (data),
    .data_valid (data_valid),
    .data_ack   (data_ack),
    .frame_err  (frame_err),
    .uart_ovf   (uart_ovf),
    .receiving  (receiving)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one full 10-bit frame; ack is pulsed on cycle ack_cyc (-1 = never).
  task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input int ack_cyc,
                            output int rise_cyc, output logic [7:0] rise_data,
                            output int hi_cnt, output int fe_cnt);
    logic [9:0] bits;
    logic       prev;
    bits      = {stop_lvl, b, 1'b0};
    rise_cyc  = -1;
    rise_data = 8'h00;
    hi_cnt    = 0;
    fe_cnt    = 0;
    for (int i = 0; i < 10 * CPB; i++) begin
      UART_RX  = bits[i / CPB];
      data_ack = (i == ack_cyc) ? 1'b1 : 1'b0;
      prev     = data_valid;
      tick();
      if (data_valid === 1'b1) hi_cnt++;
      if (frame_err === 1'b1) fe_cnt++;
      if (prev === 1'b0 && data_valid === 1'b1 && rise_cyc < 0) begin
        rise_cyc  = i;
        rise_data = data;
      end
    end
    data_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; UART_RX = 1'b1; data_ack = 1'b0;
    repeat (3) tick();
    vec_cnt++; if (data !== 8'h00) begin err_cnt++; $display("FAIL reset_data: got %h expected 00", data); end
    vec_cnt++; if (data_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b expected 0", data_valid); end
    vec_cnt++; if (frame_err !== 1'b0) begin err_cnt++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
    vec_cnt++; if (uart_ovf !== 1'b0) begin err_cnt++; $display("FAIL reset_ovf: got %b expected 0", uart_ovf); end
    vec_cnt++; if (receiving !== 1'b0) begin err_cnt++; $display("FAIL reset_recv: got %b expected 0", receiving); end
    reset = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_basic();
    int rc, hc, fc; logic [7:0] rd;
    send_frame(8'hA5, 1'b1, LAT + 5, rc, rd, hc, fc);
    vec_cnt++; if (rc !== LAT) begin err_cnt++; $display("FAIL basic_latency: got %0d expected %0d", rc, LAT); end
    vec_cnt++; if (rd !== 8'hA5) begin err_cnt++; $display("FAIL basic_data: got %h expected a5", rd); end
    vec_cnt++; if (hc !== 5) begin err_cnt++; $display("FAIL basic_valid_cycles: got %0d expected 5", hc); end
    vec_cnt++; if (fc !== 0) begin err_cnt++; $display("FAIL basic_ferr: got %0d expected 0", fc); end
    vec_cnt++; if (uart_ovf !== 1'b0) begin err_cnt++; $display("FAIL basic_ovf: got %b expected 0", uart_ovf); end
    vec_cnt++; if (data_valid !== 1'b0) begin err_cnt++; $display("FAIL basic_valid_end: got %b expected 0", data_valid); end
    repeat (20) tick();
  endtask

  task automatic test_glitch();
    logic rec_mid; int drop; int vhi;
    rec_mid = 1'b0; drop = -1; vhi = 0;
    for (int i = 0; i < 40; i++) begin
      UART_RX = 1'b0;
      tick();
      if (i == 20) rec_mid = receiving;
      if (data_valid === 1'b1) vhi++;
    end
    UART_RX = 1'b1;
    for (int j = 0; j < 100; j++) begin
      tick();
      if (data_valid === 1'b1) vhi++;
      if (receiving === 1'b0 && drop < 0) drop = 40 + j;
    end
    vec_cnt++; if (rec_mid !== 1'b1) begin err_cnt++; $display("FAIL glitch_recv_mid: got %b expected 1", rec_mid); end
    vec_cnt++; if (drop < 50 || drop > 55) begin err_cnt++; $display("FAIL glitch_recv_drop: got %0d expected 50..55", drop); end
    vec_cnt++; if (vhi !== 0) begin err_cnt++; $display("FAIL glitch_valid: got %0d expected 0", vhi); end
  endtask

  task automatic test_break();
    int rc, hc, fc, fe2, rlow, back; logic [7:0] rd;
    send_frame(8'h3C, 1'b0, -1, rc, rd, hc, fc);
    vec_cnt++; if (fc !== 1) begin err_cnt++; $display("FAIL break_ferr_pulse: got %0d expected 1", fc); end
    vec_cnt++; if (hc !== 0) begin err_cnt++; $display("FAIL break_valid: got %0d expected 0", hc); end
    fe2 = 0; rlow = 0;
    for (int i = 0; i < 2000; i++) begin
      UART_RX = 1'b0;
      tick();
      if (frame_err === 1'b1) fe2++;
      if (receiving !== 1'b1) rlow++;
    end
    vec_cnt++; if (fe2 !== 0) begin err_cnt++; $display("FAIL break_extra_ferr: got %0d expected 0", fe2); end
    vec_cnt++; if (rlow !== 0) begin err_cnt++; $display("FAIL break_recv_low: got %0d expected 0", rlow); end
    vec_cnt++; if (data_valid !== 1'b0) begin err_cnt++; $display("FAIL break_valid_end: got %b expected 0", data_valid); end
    UART_RX = 1'b1; back = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (receiving === 1'b0 && back < 0) back = i;
    end
    vec_cnt++; if (back < 0) begin err_cnt++; $display("FAIL break_release: got timeout expected receiving=0"); end
    repeat (30) tick();
    send_frame(8'h55, 1'b1, LAT + 2, rc, rd, hc, fc);
    vec_cnt++; if (rd !== 8'h55 || rc !== LAT) begin err_cnt++; $display("FAIL break_next_byte: got %h@%0d expected 55@%0d", rd, rc, LAT); end
    vec_cnt++; if (fc !== 0) begin err_cnt++; $display("FAIL break_next_ferr: got %0d expected 0", fc); end
    repeat (20) tick();
  endtask

  task automatic test_overflow();
    int rc, hc, fc; logic [7:0] rd;
    send_frame(8'h01, 1'b1, -1, rc, rd, hc, fc);
    vec_cnt++; if (data !== 8'h01 || data_valid !== 1'b1) begin err_cnt++; $display("FAIL ovf_first: got %h/%b expected 01/1", data, data_valid); end
    vec_cnt++; if (uart_ovf !== 1'b0) begin err_cnt++; $display("FAIL ovf_early: got %b expected 0", uart_ovf); end
    send_frame(8'h02, 1'b1, -1, rc, rd, hc, fc);
    vec_cnt++; if (data !== 8'h01) begin err_cnt++; $display("FAIL ovf_data_kept: got %h expected 01", data); end
    vec_cnt++; if (uart_ovf !== 1'b1) begin err_cnt++; $display("FAIL ovf_set: got %b expected 1", uart_ovf); end
    data_ack = 1'b1; tick(); data_ack = 1'b0; tick();
    vec_cnt++; if (data_valid !== 1'b0) begin err_cnt++; $display("FAIL ovf_ack_valid: got %b expected 0", data_valid); end
    vec_cnt++; if (uart_ovf !== 1'b1) begin err_cnt++; $display("FAIL ovf_sticky: got %b expected 1", uart_ovf); end
    reset = 1'b1; tick(); reset = 1'b0;
    vec_cnt++; if (uart_ovf !== 1'b0 || data !== 8'h00) begin err_cnt++; $display("FAIL ovf_reset: got %b/%h expected 0/00", uart_ovf, data); end
    repeat (10) tick();
  endtask

  task automatic test_ack_same_cycle();
    int rc, hc, fc; logic [7:0] rd;
    send_frame(8'h00, 1'b1, -1, rc, rd, hc, fc);
    vec_cnt++; if (rc !== LAT || rd !== 8'h00) begin err_cnt++; $display("FAIL same_first: got %h@%0d expected 00@%0d", rd, rc, LAT); end
    send_frame(8'hFF, 1'b1, LAT, rc, rd, hc, fc);
    vec_cnt++; if (data !== 8'hFF) begin err_cnt++; $display("FAIL same_data: got %h expected ff", data); end
    vec_cnt++; if (hc !== 10 * CPB) begin err_cnt++; $display("FAIL same_valid_held: got %0d expected %0d", hc, 10 * CPB); end
    vec_cnt++; if (uart_ovf !== 1'b0) begin err_cnt++; $display("FAIL same_ovf: got %b expected 0", uart_ovf); end
    data_ack = 1'b1; tick(); data_ack = 1'b0; tick();
    vec_cnt++; if (data_valid !== 1'b0) begin err_cnt++; $display("FAIL same_ack_clear: got %b expected 0", data_valid); end
    repeat (10) tick();
  endtask

  task automatic test_reset_mid();
    int rc, hc, fc; logic [7:0] rd; logic [9:0] bits; int vhi;
    bits = {1'b1, 8'h81, 1'b0};
    for (int i = 0; i < 350; i++) begin
      UART_RX = bits[i / CPB];
      tick();
    end
    reset = 1'b1; UART_RX = 1'b1; tick(); reset = 1'b0;
    vec_cnt++; if (receiving !== 1'b0) begin err_cnt++; $display("FAIL mid_reset_recv: got %b expected 0", receiving); end
    vhi = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (data_valid === 1'b1 || receiving === 1'b1) vhi++;
    end
    vec_cnt++; if (vhi !== 0) begin err_cnt++; $display("FAIL mid_partial_dropped: got %0d expected 0", vhi); end
    send_frame(8'h7E, 1'b1, LAT + 3, rc, rd, hc, fc);
    vec_cnt++; if (rd !== 8'h7E || rc !== LAT) begin err_cnt++; $display("FAIL mid_next_byte: got %h@%0d expected 7e@%0d", rd, rc, LAT); end
    vec_cnt++; if (hc !== 3) begin err_cnt++; $display("FAIL mid_valid_cycles: got %0d expected 3", hc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_break();
    test_overflow();
    test_ack_same_cycle();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
